// File: rtl/demux_feeder.sv
// Serialiser in front of the 2-to-1 demux: accepts 2-bit words over
// valid/ready, drives in/sel so the demux emits bits LSB first.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   word_in         - 2-bit word, captured on accept
//   word_valid      - upstream offers word_in
//   word_ready      - block can take a word this cycle (combinational)
//   in, sel         - registered drive of the demux in/sel ports
//   bit_valid       - demux output currently carries a valid bit
//   last            - final cycle of bit 1
//   busy            - a word is in flight
module demux_feeder #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  output logic [1:0] in,
  output logic       sel,
  output logic       bit_valid,
  output logic       last,
  output logic       busy
);

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
      $error("demux_feeder: HOLD_CYCLES must be 1..15");
    end
  endgenerate

  localparam logic [3:0] LASTC = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT0 = 2'd1,
    BIT1 = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       accept;

  // Ready in IDLE or on the final bit-1 cycle, so words chain
  // back-to-back without a bubble.
  always_comb begin
    word_ready = 1'b0;
    if (!rst) begin
      word_ready = (state == IDLE) ||
                   (state == BIT1 && cnt == LASTC);
    end
  end

  assign accept = word_valid && word_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      in        <= 2'b00;
      sel       <= 1'b0;
      bit_valid <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == BIT0): begin
          if (cnt == LASTC) begin
            state <= BIT1;
            cnt   <= 4'd0;
            sel   <= 1'b1;
            last  <= (LASTC == 4'd0);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        (state == BIT1): begin
          if (cnt == LASTC) begin
            last <= 1'b0;
            sel  <= 1'b0;
            cnt  <= 4'd0;
            if (accept) begin
              state <= BIT0;
              in    <= word_in;
            end else begin
              state     <= IDLE;
              bit_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end else begin
            cnt  <= cnt + 4'd1;
            // last is registered, so raise it one count early
            last <= ((cnt + 4'd1) == LASTC);
          end
        end
        default: begin
          sel       <= 1'b0;
          bit_valid <= 1'b0;
          last      <= 1'b0;
          busy      <= 1'b0;
          cnt       <= 4'd0;
          if (accept) begin
            state     <= BIT0;
            in        <= word_in;
            bit_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/demux_feeder.md
Name: demux_feeder

Overview:
- Upstream stage of the 2-to-1 selector block `demux`, whose ports are in[1:0], sel and out.
- Accepts 2-bit words through a valid/ready handshake.
- Presents each accepted word on `in`, then steps `sel` 0 then 1. The selector output therefore becomes a serial bit stream, LSB first.
- Adds framing strobes `bit_valid`, `last` and `busy` so downstream logic knows when `out` is meaningful.

Parameters:
- HOLD_CYCLES, default 1: number of clock cycles each `sel` value is held. Legal range is 1..15; any other value is an elaboration error.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- word_in  input  2  word to serialise; sampled only on an accept.
- word_valid  input  1  upstream has a word on word_in.
- word_ready  output  1  block can accept a word this cycle.
- in  output  2  drives the `in` port of `demux`; registered.
- sel  output  1  drives the `sel` port of `demux`; registered.
- bit_valid  output  1  high while the `demux` output is a valid serial bit.
- last  output  1  high on the final cycle of bit 1 of the word.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values (after a rising edge with rst=1): state=IDLE, in=2'b00, sel=0, bit_valid=0, last=0, busy=0, hold counter=0.
- word_ready is forced to 0 while rst=1.
- Accept: an accept occurs on a rising edge where word_valid=1 and word_ready=1. word_in is captured into `in` at that edge.
- word_ready is combinational: 1 when state=IDLE, or when state=BIT1 and hold counter=HOLD_CYCLES-1. It is 0 otherwise.
- States:
  - IDLE: sel=0, bit_valid=0, busy=0; `in` keeps the last word. On accept, go to BIT0 with counter=0.
  - BIT0: sel=0, bit_valid=1, busy=1. The counter increments each cycle. When counter=HOLD_CYCLES-1, go to BIT1 with counter=0.
  - BIT1: sel=1, bit_valid=1, busy=1. last=1 only when counter=HOLD_CYCLES-1. At that count:
    - with an accept, go to BIT0, counter=0, new word on `in`;
    - without an accept, go to IDLE.
- Latency: a word accepted at edge N appears on `in` with sel=0 and bit_valid=1 in the cycle after edge N.
- Throughput: exactly 2*HOLD_CYCLES cycles per word; back-to-back words have no bubble.
- Stability: `in` stays constant across both bit phases of a word. `sel` changes only at phase boundaries.
- word_valid while busy and not on the final BIT1 cycle: no accept. Upstream must hold word_in and word_valid until it sees word_ready.
- word_in changing while not accepted has no effect.
- Reset mid-word: at the next edge all outputs take their reset values and the in-flight word is discarded. rst=1 overrides a simultaneous accept.
- Counter width is 4 bits. It never exceeds HOLD_CYCLES-1 and does not wrap.

Test Plan:
- Reset then idle, HOLD_CYCLES=1, rst high for 2 cycles, then word_valid=0 for 5 cycles -> word_ready=0 during rst then 1; in=00, sel=0, bit_valid=0, busy=0 throughout.
- Single word, HOLD_CYCLES=1, word_in=2'b10 accepted at edge N:
  - cycle N+1: in=10, sel=0, bit_valid=1, last=0;
  - cycle N+2: sel=1, last=1, word_ready=1;
  - cycle N+3: IDLE, bit_valid=0, in still 10.
- Back-to-back, HOLD_CYCLES=1, words 01, 11, 00 with word_valid held high -> sel toggles 0,1,0,1,0,1 with bit_valid continuously 1; in=01,01,11,11,00,00; last on cycles 2, 4 and 6.
- Stretched hold, HOLD_CYCLES=3, word 11 -> sel=0 for 3 cycles, then sel=1 for 3 cycles; last only on cycle 6; word_ready=0 on cycles 1-5, 1 on cycle 6.
- Backpressure, HOLD_CYCLES=1: word 01 in flight, word_valid=1 with word_in=10 presented during BIT0 -> no accept in BIT0; accept on the BIT1 edge; next cycle in=10, sel=0.
- Reset mid-word, HOLD_CYCLES=3: rst=1 asserted during BIT0 cycle 2 of word 10, together with word_valid=1 -> next cycle all outputs at reset values, no accept; after rst drops, the next accept starts cleanly at BIT0.
